// File: rtl/fork_join_scheduler.sv
// Fork-join control: forks each accepted token to two branches, joins the results in tag order, fires the adder.
// Optional FORK_JOIN_PERF_EN adds perf_tokens / perf_stall saturating counters.
module fork_join_scheduler #(
    parameter int unsigned  MAX_INFLIGHT = 4,
    parameter int unsigned  TAG_W        = 3,
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             fork_a_valid,
    input  logic             fork_a_ready,
    output logic             fork_b_valid,
    input  logic             fork_b_ready,
    output logic [TAG_W-1:0] fork_tag,
    input  logic             join_a_valid,
    output logic             join_a_ready,
    input  logic [TAG_W-1:0] join_a_tag,
    input  logic             join_b_valid,
    output logic             join_b_ready,
    input  logic [TAG_W-1:0] join_b_tag,
    output logic             add_fire,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] inflight,
    output logic             tag_err
`ifdef FORK_JOIN_PERF_EN
    ,
    output logic [31:0]      perf_tokens,
    output logic [31:0]      perf_stall
`endif
);

    typedef enum logic {F_IDLE, F_SEND} fork_state_e;
    typedef enum logic [1:0] {J_COLLECT, J_FIRE, J_OUT} join_state_e;

    fork_state_e      fork_state_q, fork_state_d;
    join_state_e      join_state_q, join_state_d;
    logic             in_ready_q, in_ready_d;
    logic             fa_valid_q, fa_valid_d;
    logic             fb_valid_q, fb_valid_d;
    logic [TAG_W-1:0] fork_tag_q, fork_tag_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
    logic             ja_ready_q, ja_ready_d;
    logic             jb_ready_q, jb_ready_d;
    logic             a_got_q, a_got_d;
    logic             b_got_q, b_got_d;
    logic             add_fire_q, add_fire_d;
    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [TAG_W-1:0] expect_tag_q, expect_tag_d;
    logic             tag_err_q, tag_err_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic accept, out_xfer, a_xfer, b_xfer, has_room;

    assign accept   = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;
    assign a_xfer   = join_a_valid && ja_ready_q;
    assign b_xfer   = join_b_valid && jb_ready_q;

    // Occupancy after this edge; in_ready looks ahead so a freed slot is usable next cycle
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !out_xfer) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && out_xfer) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    assign has_room = (inflight_d < CNT_W'(MAX_INFLIGHT));

    // Fork FSM: each branch valid retires independently; tag advances once both have taken the token
    always_comb begin
        fork_state_d = fork_state_q;
        in_ready_d   = 1'b0;
        fa_valid_d   = fa_valid_q;
        fb_valid_d   = fb_valid_q;
        fork_tag_d   = fork_tag_q;
        issue_tag_d  = issue_tag_q;
        case (fork_state_q)
            F_IDLE: begin
                if (accept) begin
                    fork_state_d = F_SEND;
                    fa_valid_d   = 1'b1;
                    fb_valid_d   = 1'b1;
                    fork_tag_d   = issue_tag_q;
                end else begin
                    in_ready_d = has_room;
                end
            end
            F_SEND: begin
                if (fork_a_ready) fa_valid_d = 1'b0;
                if (fork_b_ready) fb_valid_d = 1'b0;
                if (!fa_valid_d && !fb_valid_d) begin
                    fork_state_d = F_IDLE;
                    issue_tag_d  = issue_tag_q + TAG_W'(1);
                    in_ready_d   = has_room;
                end
            end
            default: fork_state_d = F_IDLE;
        endcase
    end

    // Join FSM: collect both results, pulse the adder, hold the sum until downstream takes it
    always_comb begin
        join_state_d = join_state_q;
        ja_ready_d   = 1'b0;
        jb_ready_d   = 1'b0;
        a_got_d      = a_got_q;
        b_got_d      = b_got_q;
        add_fire_d   = 1'b0;
        out_valid_d  = out_valid_q;
        out_tag_d    = out_tag_q;
        expect_tag_d = expect_tag_q;
        tag_err_d    = tag_err_q;
        case (join_state_q)
            J_COLLECT: begin
                if (a_xfer) begin
                    a_got_d = 1'b1;
                    if (join_a_tag != expect_tag_q) tag_err_d = 1'b1;
                end
                if (b_xfer) begin
                    b_got_d = 1'b1;
                    if (join_b_tag != expect_tag_q) tag_err_d = 1'b1;
                end
                if (a_got_d && b_got_d) begin
                    join_state_d = J_FIRE;
                    add_fire_d   = 1'b1;
                    out_tag_d    = expect_tag_q;
                    a_got_d      = 1'b0;
                    b_got_d      = 1'b0;
                end else begin
                    ja_ready_d = !a_got_d;
                    jb_ready_d = !b_got_d;
                end
            end
            J_FIRE: begin
                join_state_d = J_OUT;
                out_valid_d  = 1'b1;
            end
            J_OUT: begin
                if (out_ready) begin
                    join_state_d = J_COLLECT;
                    out_valid_d  = 1'b0;
                    expect_tag_d = expect_tag_q + TAG_W'(1);
                    ja_ready_d   = 1'b1;
                    jb_ready_d   = 1'b1;
                end
            end
            default: join_state_d = J_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fork_state_q <= F_IDLE;
            join_state_q <= J_COLLECT;
            in_ready_q   <= 1'b0;
            fa_valid_q   <= 1'b0;
            fb_valid_q   <= 1'b0;
            fork_tag_q   <= '0;
            issue_tag_q  <= '0;
            ja_ready_q   <= 1'b0;
            jb_ready_q   <= 1'b0;
            a_got_q      <= 1'b0;
            b_got_q      <= 1'b0;
            add_fire_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            expect_tag_q <= '0;
            tag_err_q    <= 1'b0;
            inflight_q   <= '0;
        end else begin
            fork_state_q <= fork_state_d;
            join_state_q <= join_state_d;
            in_ready_q   <= in_ready_d;
            fa_valid_q   <= fa_valid_d;
            fb_valid_q   <= fb_valid_d;
            fork_tag_q   <= fork_tag_d;
            issue_tag_q  <= issue_tag_d;
            ja_ready_q   <= ja_ready_d;
            jb_ready_q   <= jb_ready_d;
            a_got_q      <= a_got_d;
            b_got_q      <= b_got_d;
            add_fire_q   <= add_fire_d;
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            expect_tag_q <= expect_tag_d;
            tag_err_q    <= tag_err_d;
            inflight_q   <= inflight_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign fork_a_valid = fa_valid_q;
    assign fork_b_valid = fb_valid_q;
    assign fork_tag     = fork_tag_q;
    assign join_a_ready = ja_ready_q;
    assign join_b_ready = jb_ready_q;
    assign add_fire     = add_fire_q;
    assign out_valid    = out_valid_q;
    assign out_tag      = out_tag_q;
    assign inflight     = inflight_q;
    assign tag_err      = tag_err_q;

`ifdef FORK_JOIN_PERF_EN
    logic [31:0] perf_tokens_q, perf_stall_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_tokens_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (out_xfer && (perf_tokens_q != '1)) perf_tokens_q <= perf_tokens_q + 32'd1;
            if (in_valid && !in_ready_q && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_tokens = perf_tokens_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_fork_join_scheduler.sv
// Directed bench for fork_join_scheduler: single token, skewed fork, out-of-order join, full, tag wrap, mid-flight reset.
module tb_fork_join_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic       fork_a_valid, fork_a_ready, fork_b_valid, fork_b_ready;
    logic [2:0] fork_tag;
    logic       join_a_valid, join_a_ready, join_b_valid, join_b_ready;
    logic [2:0] join_a_tag, join_b_tag;
    logic       add_fire, out_valid, out_ready;
    logic [2:0] out_tag;
    logic [2:0] inflight;
    logic       tag_err;
`ifdef FORK_JOIN_PERF_EN
    logic [31:0] perf_tokens, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int accepted;

    fork_join_scheduler #(.MAX_INFLIGHT(4), .TAG_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fork_a_valid (fork_a_valid),
        .fork_a_ready (fork_a_ready),
        .fork_b_valid (fork_b_valid),
        .fork_b_ready (fork_b_ready),
        .fork_tag     (fork_tag),
        .join_a_valid (join_a_valid),
        .join_a_ready (join_a_ready),
        .join_a_tag   (join_a_tag),
        .join_b_valid (join_b_valid),
        .join_b_ready (join_b_ready),
        .join_b_tag   (join_b_tag),
        .add_fire     (add_fire),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_tag      (out_tag),
        .inflight     (inflight),
        .tag_err      (tag_err)
`ifdef FORK_JOIN_PERF_EN
        ,
        .perf_tokens  (perf_tokens),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one token with both branches ready; fork must last exactly one cycle
    task automatic send_token(input int exp_tag);
        fork_a_ready = 1'b1;
        fork_b_ready = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        chk("send_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("send_fa_valid", 32'(fork_a_valid), 1);
        chk("send_fb_valid", 32'(fork_b_valid), 1);
        chk("send_fork_tag", 32'(fork_tag), exp_tag);
        step();
        chk("send_fa_drop", 32'(fork_a_valid), 0);
        chk("send_fb_drop", 32'(fork_b_valid), 0);
    endtask

    // Present both branch results together; expects add_fire next cycle, out_valid after, out_ready held 1
    task automatic join_and_out(input logic [2:0] ta, input logic [2:0] tb, input int exp_tag);
        for (int i = 0; i < 20 && !(join_a_ready && join_b_ready); i++) step();
        chk("join_readies", 32'(join_a_ready && join_b_ready), 1);
        join_a_valid = 1'b1;
        join_a_tag   = ta;
        join_b_valid = 1'b1;
        join_b_tag   = tb;
        step();
        join_a_valid = 1'b0;
        join_b_valid = 1'b0;
        chk("join_add_fire", 32'(add_fire), 1);
        chk("join_ra_low", 32'(join_a_ready), 0);
        step();
        chk("join_add_once", 32'(add_fire), 0);
        chk("join_out_valid", 32'(out_valid), 1);
        chk("join_out_tag", 32'(out_tag), exp_tag);
        step();
        chk("join_out_done", 32'(out_valid), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        fork_a_ready = 1'b0;
        fork_b_ready = 1'b0;
        join_a_valid = 1'b0;
        join_b_valid = 1'b0;
        join_a_tag   = 3'd0;
        join_b_tag   = 3'd0;
        out_ready    = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_fa_valid", 32'(fork_a_valid), 0);
        chk("rst_fb_valid", 32'(fork_b_valid), 0);
        chk("rst_ja_ready", 32'(join_a_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_add_fire", 32'(add_fire), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_tag_err", 32'(tag_err), 0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_ja_ready", 32'(join_a_ready), 1);
        chk("idle_jb_ready", 32'(join_b_ready), 1);
        chk("idle_no_fire", 32'(add_fire), 0);

        // Single token, all readies high
        out_ready = 1'b1;
        send_token(0);
        chk("single_in_ready", 32'(in_ready), 1);
        chk("single_inflight", 32'(inflight), 1);
        join_and_out(3'd0, 3'd0, 0);
        chk("single_inflight_0", 32'(inflight), 0);

        // Skewed fork: A takes at +1, B at +5
        fork_a_ready = 1'b0;
        fork_b_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("skew_fa_up", 32'(fork_a_valid), 1);
        chk("skew_fb_up", 32'(fork_b_valid), 1);
        chk("skew_tag", 32'(fork_tag), 1);
        fork_a_ready = 1'b1;
        step();
        fork_a_ready = 1'b0;
        chk("skew_fa_drop", 32'(fork_a_valid), 0);
        chk("skew_fb_hold", 32'(fork_b_valid), 1);
        chk("skew_in_busy", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("skew_fb_hold_n", 32'(fork_b_valid), 1);
            chk("skew_in_busy_n", 32'(in_ready), 0);
        end
        fork_b_ready = 1'b1;
        step();
        chk("skew_fb_drop", 32'(fork_b_valid), 0);
        chk("skew_in_ready", 32'(in_ready), 1);

        // Join order: B result 4 cycles before A
        join_b_valid = 1'b1;
        join_b_tag   = 3'd1;
        step();
        join_b_valid = 1'b0;
        chk("order_jb_taken", 32'(join_b_ready), 0);
        chk("order_ja_wait", 32'(join_a_ready), 1);
        chk("order_no_fire", 32'(add_fire), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("order_no_fire_n", 32'(add_fire), 0);
            chk("order_no_out_n", 32'(out_valid), 0);
        end
        join_a_valid = 1'b1;
        join_a_tag   = 3'd1;
        step();
        join_a_valid = 1'b0;
        chk("order_fire", 32'(add_fire), 1);
        step();
        chk("order_fire_once", 32'(add_fire), 0);
        chk("order_out_valid", 32'(out_valid), 1);
        chk("order_out_tag", 32'(out_tag), 1);
        step();
        chk("order_out_done", 32'(out_valid), 0);
        chk("order_inflight", 32'(inflight), 0);
        chk("order_tag_err", 32'(tag_err), 0);

        // Full: downstream blocked, source streams continuously
        out_ready    = 1'b0;
        fork_a_ready = 1'b1;
        fork_b_ready = 1'b1;
        accepted     = 0;
        in_valid     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (in_ready && accepted < 6) accepted++;
            step();
        end
        in_valid = 1'b0;
        chk("full_accepted", accepted, 4);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_inflight", 32'(inflight), 4);
        chk("full_no_out", 32'(out_valid), 0);

        // Drain; one output frees a slot next cycle; tag 4 joined with A tag 5
        out_ready = 1'b1;
        join_and_out(3'd2, 3'd2, 2);
        chk("drain_inflight_3", 32'(inflight), 3);
        chk("drain_in_ready", 32'(in_ready), 1);
        join_and_out(3'd3, 3'd3, 3);
        chk("drain_tag_err_0", 32'(tag_err), 0);
        join_and_out(3'd5, 3'd4, 4);
        chk("mismatch_tag_err", 32'(tag_err), 1);
        join_and_out(3'd5, 3'd5, 5);
        chk("drain_inflight_0", 32'(inflight), 0);

        // Tag wrap: tokens 6,7,0,1
        send_token(6);
        join_and_out(3'd6, 3'd6, 6);
        send_token(7);
        join_and_out(3'd7, 3'd7, 7);
        send_token(0);
        join_and_out(3'd0, 3'd0, 0);
        send_token(1);
        join_and_out(3'd1, 3'd1, 1);
        chk("wrap_tag_err_sticky", 32'(tag_err), 1);
        chk("wrap_inflight", 32'(inflight), 0);

        // Reset with fork pending and sum pending
        fork_a_ready = 1'b0;
        fork_b_ready = 1'b0;
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mid_fa_valid", 32'(fork_a_valid), 1);
        chk("mid_fork_tag", 32'(fork_tag), 2);
        join_a_valid = 1'b1;
        join_a_tag   = 3'd2;
        join_b_valid = 1'b1;
        join_b_tag   = 3'd2;
        step();
        join_a_valid = 1'b0;
        join_b_valid = 1'b0;
        step();
        chk("mid_out_valid", 32'(out_valid), 1);
        chk("mid_fb_valid", 32'(fork_b_valid), 1);
        chk("mid_inflight", 32'(inflight), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_fa_valid", 32'(fork_a_valid), 0);
        chk("arst_fb_valid", 32'(fork_b_valid), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_inflight", 32'(inflight), 0);
        chk("arst_tag_err", 32'(tag_err), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send_token(0);
        join_and_out(3'd0, 3'd0, 0);
        chk("post_rst_tag_err", 32'(tag_err), 0);
        chk("post_rst_inflight", 32'(inflight), 0);
`ifdef FORK_JOIN_PERF_EN
        chk("perf_tokens", perf_tokens, 1);
        chk("perf_stall", perf_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
